router_ctrl: RTL and testbench

- Packet-sequencing controller for the 1x3 router.
- Accepts the byte stream on the source side: data_in, pkt_valid, with busy and error returned to the source.
- Decodes the destination, steers header/payload/parity bytes into one of three output FIFOs, and throttles the source via busy.
- Checks parity and length; drives per-port valid_out; issues per-port soft_reset when a destination stalls reading.

---
 rtl/router_pkg.sv | 38 +++
 rtl/router_ctrl_if.sv | 27 ++
 rtl/router_sync_timer.sv | 37 +++
 rtl/router_ctrl.sv | 168 ++++++++++++++++
 tb/tb_router_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared types, header field layout and helpers for the 1x3 router packet controller.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LFD,
        LOAD_DATA,
        FULL,
        LOAD_AFTER_FULL,
        CHECK,
        DROP
    } state_t;

    localparam logic [1:0]  ADDR_INVALID = 2'b11;
    localparam int unsigned TIMEOUT_DEF  = 30;

    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    function automatic logic [2:0] port_onehot(input logic [1:0] addr);
        case (addr)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // The source may only advance in states that consume bytes.
    function automatic logic busy_of(input state_t s);
        return !(s inside {IDLE, LOAD_DATA, DROP});
    endfunction

endpackage

// File: rtl/router_ctrl_if.sv
// Source byte stream, FIFO status/strobes and per-port flush signals of the router controller.
interface router_ctrl_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              error;
    logic [2:0]        fifo_full;
    logic [2:0]        fifo_empty;
    logic [2:0]        read_enb;
    logic [DATA_W-1:0] dout;
    logic [2:0]        write_enb;
    logic              lfd_state;
    logic [2:0]        valid_out;
    logic [2:0]        soft_reset;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        input  busy, error, dout, write_enb, lfd_state, valid_out, soft_reset
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        output busy, error, dout, write_enb, lfd_state, valid_out, soft_reset
    );
endinterface

// File: rtl/router_sync_timer.sv
// Per-port read-stall watchdog: pulses soft_reset_o for one cycle after TIMEOUT unread cycles.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    input  logic read_i,
    output logic soft_reset_o
);
    logic [CNT_W-1:0] cnt_q;
    logic             soft_reset_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            soft_reset_q <= 1'b0;
            if (valid_i && !read_i) begin
                if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cnt_q        <= '0;
                    soft_reset_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign soft_reset_o = soft_reset_q;
endmodule

// File: rtl/router_ctrl.sv
// Packet sequencer for the 1x3 router: steers header/payload/parity into the addressed FIFO,
// throttles the source, checks parity/length and flushes stalled destinations.
module router_ctrl
    import router_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 5
) (
    input logic          clk,
    input logic          reset,
    router_ctrl_if.slave rif
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] hdr_q, par_q, rx_par_q, hold_q, dout_q;
    logic [1:0]        addr_q;
    logic [LEN_W-1:0]  len_q, cnt_q;
    logic              hold_is_par_q, busy_q, error_q, lfd_q;
    logic [2:0]        write_enb_q;
    logic [2:0]        soft_reset;

    logic [1:0]       hdr_addr;
    logic [LEN_W-1:0] hdr_len;
    logic [2:0]       port_sel;
    logic             full_sel, empty_sel, srst_sel, hdr_empty;

    assign hdr_addr  = rif.data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign hdr_len   = rif.data_in[HDR_LEN_MSB:HDR_LEN_LSB];
    assign port_sel  = port_onehot(addr_q);
    assign full_sel  = |(rif.fifo_full & port_sel);
    assign empty_sel = |(rif.fifo_empty & port_sel);
    assign srst_sel  = |(soft_reset & port_sel);
    assign hdr_empty = |(rif.fifo_empty & port_onehot(hdr_addr));

    for (genvar g = 0; g < 3; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT(TIMEOUT),
            .CNT_W  (CNT_W)
        ) u_timer (
            .clk         (clk),
            .reset       (reset),
            .valid_i     (rif.valid_out[g]),
            .read_i      (rif.read_enb[g]),
            .soft_reset_o(soft_reset[g])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rif.pkt_valid) begin
                    if (hdr_addr == ADDR_INVALID || hdr_len == '0) state_d = DROP;
                    else if (hdr_empty)                             state_d = LFD;
                    else                                            state_d = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                if (srst_sel)       state_d = DROP;
                else if (empty_sel) state_d = LFD;
            end
            LFD: state_d = srst_sel ? DROP : LOAD_DATA;
            LOAD_DATA: begin
                // A parity byte that can be written completes the packet even under a flush.
                if (!rif.pkt_valid && !full_sel) state_d = CHECK;
                else if (srst_sel)               state_d = DROP;
                else if (full_sel)               state_d = FULL;
            end
            FULL: begin
                if (srst_sel)       state_d = DROP;
                else if (!full_sel) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (hold_is_par_q) state_d = CHECK;
                else if (srst_sel) state_d = DROP;
                else               state_d = LOAD_DATA;
            end
            CHECK: state_d = IDLE;
            DROP:  if (!rif.pkt_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            write_enb_q   <= '0;
            dout_q        <= '0;
            lfd_q         <= 1'b0;
            hdr_q         <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            par_q         <= '0;
            rx_par_q      <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            hold_is_par_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_of(state_d);
            write_enb_q <= '0;
            lfd_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rif.pkt_valid) begin
                        hdr_q         <= rif.data_in;
                        addr_q        <= hdr_addr;
                        len_q         <= hdr_len;
                        par_q         <= rif.data_in;
                        cnt_q         <= '0;
                        error_q       <= 1'b0;
                        hold_is_par_q <= 1'b0;
                        if (state_d == LFD) begin
                            write_enb_q <= port_onehot(hdr_addr);
                            dout_q      <= rif.data_in;
                            lfd_q       <= 1'b1;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    if (state_d == LFD) begin
                        write_enb_q <= port_sel;
                        dout_q      <= hdr_q;
                        lfd_q       <= 1'b1;
                    end
                end
                LOAD_DATA: begin
                    if (state_d != DROP) begin
                        if (rif.pkt_valid) begin
                            par_q         <= par_q ^ rif.data_in;
                            hold_is_par_q <= 1'b0;
                            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        end else begin
                            rx_par_q      <= rif.data_in;
                            hold_is_par_q <= 1'b1;
                        end
                        if (full_sel) begin
                            hold_q <= rif.data_in;
                        end else begin
                            write_enb_q <= port_sel;
                            dout_q      <= rif.data_in;
                        end
                    end
                end
                FULL: begin
                    if (state_d == LOAD_AFTER_FULL) begin
                        write_enb_q <= port_sel;
                        dout_q      <= hold_q;
                    end
                end
                CHECK:   error_q <= (rx_par_q != par_q) || (cnt_q != len_q);
                DROP:    if (!rif.pkt_valid) error_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign rif.busy       = busy_q;
    assign rif.error      = error_q;
    assign rif.write_enb  = write_enb_q;
    assign rif.dout       = dout_q;
    assign rif.lfd_state  = lfd_q;
    assign rif.valid_out  = ~rif.fifo_empty;
    assign rif.soft_reset = soft_reset;
endmodule

// File: tb/tb_router_ctrl.sv
// Directed and randomized checks of router_ctrl against a packet-level reference model.
module tb_router_ctrl;
    typedef logic [10:0] ent_t;  // {port, lfd, byte}

    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_ctrl_if #(.DATA_W(8)) rif ();

    router_ctrl #(
        .DATA_W (8),
        .TIMEOUT(30),
        .CNT_W  (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rif  (rif)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int cur_idx;
    bit rnd_done;

    logic [7:0] pl_q[$];
    logic [8:0] pk_q[$];
    ent_t       ex_q[$];
    logic       ex_err;
    ent_t       obs_q[$];
    int         obs_cyc[$];
    int         acc_cyc[$];
    int         stall[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b0 && rif.write_enb !== 3'b000) begin
            logic [1:0] p;
            case (rif.write_enb)
                3'b001:  p = 2'd0;
                3'b010:  p = 2'd1;
                3'b100:  p = 2'd2;
                default: p = 2'd3;
            endcase
            obs_q.push_back({p, rif.lfd_state, rif.dout});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] good_par(input logic [7:0] hdr);
        logic [7:0] x = hdr;
        foreach (pl_q[i]) x ^= pl_q[i];
        return x;
    endfunction

    // Packet-level model: what lands in which FIFO and whether error is flagged.
    task automatic build(input logic [7:0] hdr, input logic [7:0] parity);
        logic [1:0] a   = hdr[1:0];
        int         len = int'(hdr[7:2]);
        pk_q.delete();
        ex_q.delete();
        pk_q.push_back({1'b1, hdr});
        foreach (pl_q[i]) pk_q.push_back({1'b1, pl_q[i]});
        pk_q.push_back({1'b0, parity});
        if (a == 2'd3 || len == 0) begin
            ex_err = 1'b1;
        end else begin
            ex_q.push_back({a, 1'b1, hdr});
            foreach (pl_q[i]) ex_q.push_back({a, 1'b0, pl_q[i]});
            ex_q.push_back({a, 1'b0, parity});
            ex_err = (parity != good_par(hdr)) || (pl_q.size() != len);
        end
    endtask

    task automatic send();
        acc_cyc.delete();
        stall.delete();
        cur_idx = -1;
        foreach (pk_q[i]) begin
            int w = 0;
            @(negedge clk);
            rif.pkt_valid = pk_q[i][8];
            rif.data_in   = pk_q[i][7:0];
            cur_idx       = i;
            while (rif.busy !== 1'b0 && w < BUDGET) begin
                @(negedge clk);
                w++;
            end
            check($sformatf("consume_%0d", i), rif.busy, 1'b0);
            if (rif.busy !== 1'b0) return;
            acc_cyc.push_back(cyc + 1);
            stall.push_back(w);
        end
        @(negedge clk);
        rif.pkt_valid = 1'b0;
        rif.data_in   = '0;
        cur_idx       = pk_q.size();
    endtask

    task automatic wait_idle();
        int w = 0;
        while (rif.busy !== 1'b0 && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        check("idle_return", rif.busy, 1'b0);
    endtask

    task automatic compare(input string tag);
        check({tag, "_nwr"}, obs_q.size(), ex_q.size());
        for (int i = 0; i < ex_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), obs_q[i], ex_q[i]);
        check({tag, "_err"}, rif.error, ex_err);
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_idx(input int target);
        int k = 0;
        while (cur_idx < target && k < BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        rif.pkt_valid  = 1'b0;
        rif.data_in    = '0;
        rif.fifo_full  = 3'b000;
        rif.fifo_empty = 3'b111;
        rif.read_enb   = 3'b111;
        repeat (3) @(negedge clk);
        check("rst_busy", rif.busy, 1'b0);
        check("rst_error", rif.error, 1'b0);
        check("rst_wen", rif.write_enb, 3'b000);
        check("rst_lfd", rif.lfd_state, 1'b0);
        check("rst_srst", rif.soft_reset, 3'b000);
        check("rst_vout", rif.valid_out, 3'b000);
        reset = 1'b0;
        rif.fifo_empty = 3'b010;
        #1 check("vout_comb", rif.valid_out, 3'b101);
        rif.fifo_empty = 3'b111;

        // Nominal packet to port 1.
        pl_q = '{8'h11, 8'h22, 8'h33};
        build(8'h0D, 8'h0D);
        send();
        wait_idle();
        check("nom_hdr_lat", obs_cyc.size() > 0 ? obs_cyc[0] : -1, acc_cyc.size() > 0 ? acc_cyc[0] : -2);
        check("nom_stall_hdr", stall.size() > 0 ? stall[0] : -1, 0);
        check("nom_stall_lfd", stall.size() > 1 ? stall[1] : -1, 1);
        compare("nom");

        // Bad parity.
        build(8'h0D, 8'h0E);
        send();
        wait_idle();
        compare("badpar");

        // Invalid address: error clears on header, never busy, nothing written.
        pl_q = '{8'hAA};
        build(8'h07, 8'h5A);
        fork
            send();
            begin
                wait_idx(1);
                check("err_clr", rif.error, 1'b0);
                while (cur_idx < pk_q.size()) begin
                    check("inv_busy", rif.busy, 1'b0);
                    @(negedge clk);
                    #1;
                end
            end
        join
        wait_idle();
        compare("inv");

        // Destination not empty: wait, then header written with nothing lost.
        rif.fifo_empty = 3'b110;
        pl_q = '{8'h55};
        build(8'h04, good_par(8'h04));
        fork
            send();
            begin
                wait_idx(1);
                check("we_vout", rif.valid_out, 3'b001);
                repeat (5) begin
                    check("we_busy", rif.busy, 1'b1);
                    check("we_nowr", rif.write_enb, 3'b000);
                    @(negedge clk);
                    #1;
                end
                rif.fifo_empty = 3'b111;
            end
        join
        wait_idle();
        compare("wempty");

        // FIFO full on the 2nd payload byte for 4 cycles.
        pl_q = '{8'hA1, 8'hB2, 8'hC3};
        build(8'h0E, good_par(8'h0E));
        fork
            send();
            begin
                wait_idx(2);
                rif.fifo_full = 3'b100;
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    check("full_busy", rif.busy, 1'b1);
                    check("full_nowr", rif.write_enb, 3'b000);
                end
                rif.fifo_full = 3'b000;
            end
        join
        wait_idle();
        compare("full");

        // Timeout on port 2, then a read one cycle short of expiry restarts the count.
        @(negedge clk);
        rif.fifo_empty = 3'b011;
        rif.read_enb   = 3'b011;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            check($sformatf("tmo_%0d", k), rif.soft_reset, (k == 30) ? 3'b100 : 3'b000);
        end
        rif.read_enb = 3'b111;
        @(negedge clk);
        rif.read_enb = 3'b011;
        repeat (28) @(negedge clk);
        rif.read_enb = 3'b111;
        @(negedge clk);
        rif.read_enb = 3'b011;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("tmo_rs_%0d", k), rif.soft_reset, (k == 30) ? 3'b100 : 3'b000);
        end
        rif.read_enb   = 3'b111;
        rif.fifo_empty = 3'b111;
        @(negedge clk);

        // Stalled destination flushed while waiting for it: packet dropped.
        rif.fifo_empty = 3'b101;
        rif.read_enb   = 3'b101;
        pl_q = '{8'h11, 8'h22, 8'h33};
        build(8'h0D, 8'h0D);
        ex_q.delete();
        ex_err = 1'b1;
        send();
        wait_idle();
        compare("srst_drop");
        rif.fifo_empty = 3'b111;
        rif.read_enb   = 3'b111;

        // Reset in the middle of a packet.
        @(negedge clk);
        rif.pkt_valid = 1'b1;
        rif.data_in   = 8'h0D;
        @(negedge clk);
        rif.data_in = 8'h11;
        repeat (2) @(negedge clk);
        reset         = 1'b1;
        rif.pkt_valid = 1'b0;
        rif.data_in   = '0;
        @(negedge clk);
        check("mid_rst_busy", rif.busy, 1'b0);
        check("mid_rst_wen", rif.write_enb, 3'b000);
        check("mid_rst_lfd", rif.lfd_state, 1'b0);
        check("mid_rst_err", rif.error, 1'b0);
        obs_q.delete();
        obs_cyc.delete();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_nowr", obs_q.size(), 0);
        build(8'h0D, 8'h0D);
        send();
        wait_idle();
        compare("post_rst");

        // Randomized packets with random FIFO full/empty behaviour.
        rnd_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 30; p++) begin
                    logic [1:0] a;
                    int         len, n;
                    logic [7:0] hdr;
                    a   = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    len = $urandom_range(0, 6);
                    n   = len;
                    if ($urandom_range(0, 5) == 0) n = len + 1;
                    else if (len > 0 && $urandom_range(0, 5) == 0) n = len - 1;
                    hdr = {6'(len), a};
                    pl_q.delete();
                    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
                    build(hdr, ($urandom_range(0, 3) == 0) ? 8'($urandom) : good_par(hdr));
                    send();
                    wait_idle();
                    compare($sformatf("rnd%0d", p));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    #2;
                    for (int b = 0; b < 3; b++) begin
                        rif.fifo_full[b] = ($urandom_range(0, 3) == 0);
                        if (!rif.fifo_empty[b]) rif.fifo_empty[b] = ($urandom_range(0, 2) == 0);
                        else                    rif.fifo_empty[b] = ($urandom_range(0, 9) != 0);
                    end
                end
                rif.fifo_full  = 3'b000;
                rif.fifo_empty = 3'b111;
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
